// File: rtl/lc3b_fetch_unit_if.sv
// lc3b_fetch_unit_if
//   Bundles the fetch stage's redirect input, instruction-memory read port
//   and the valid/ready instruction hand-off toward the IR/decode stage.
//   master : the fetch unit (drives mem_read/mem_address and instr_*)
//   slave  : the environment (memory, branch/redirect logic, decode stage)
interface lc3b_fetch_unit_if;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        mem_read;
  logic [15:0] mem_address;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;

  modport master (
    input  redirect, redirect_pc, mem_resp, mem_rdata, instr_ready,
    output mem_read, mem_address, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect, redirect_pc, mem_resp, mem_rdata, instr_ready,
    input  mem_read, mem_address, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/lc3b_fetch_unit.sv
// lc3b_fetch_unit
//   LC-3b instruction fetch stage. Owns the fetch PC, issues single
//   outstanding word reads, buffers returned words tagged with their PC in
//   an in-order queue of DEPTH entries, and presents the queue head to the
//   IR/decode stage. A redirect flushes the queue and restarts fetch; a read
//   still in flight at that moment is completed and its data dropped.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - lc3b_fetch_unit_if.master: redirect/redirect_pc, mem_read,
//           mem_address, mem_resp, mem_rdata, instr_valid, instr, instr_pc,
//           instr_ready
module lc3b_fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic                clk,
  input logic                rst_n,
  lc3b_fetch_unit_if.master  bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic          r_mem_read, w_mem_read_nxt;
  logic [15:0]   r_mem_addr, w_mem_addr_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [PW-1:0] r_head, r_tail;
  logic [15:0]   r_q_instr [DEPTH];
  logic [15:0]   r_q_pc    [DEPTH];

  logic w_resp;
  logic w_push;
  logic w_pop;

  always_comb begin
    w_resp = r_mem_read & bus.mem_resp;
    // Redirect wins over both a same-cycle push and a same-cycle pop.
    w_push = (r_state == FETCH) & w_resp & ~bus.redirect;
    w_pop  = (r_count != '0) & bus.instr_ready & ~bus.redirect;

    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_count_nxt    = r_count;
    w_mem_read_nxt = r_mem_read;
    w_mem_addr_nxt = r_mem_addr;

    if (bus.redirect) begin
      w_count_nxt    = '0;
      w_fetch_pc_nxt = bus.redirect_pc & 16'hFFFE;
      // An unanswered read must still complete before a new one may start.
      w_state_nxt    = (r_mem_read && !bus.mem_resp) ? DISCARD : FETCH;
    end else begin
      case (r_state)
        FETCH:   if (w_push) w_fetch_pc_nxt = r_fetch_pc + 16'd2;
        DISCARD: if (w_resp) w_state_nxt = FETCH;
        default: w_state_nxt = FETCH;
      endcase
      if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
      else if (w_pop && !w_push) w_count_nxt = r_count - CW'(1);
    end

    // Request generation looks at next-cycle state so a new read can follow
    // a response back-to-back; an unanswered read holds its address.
    if (!(r_mem_read && !bus.mem_resp)) begin
      if (w_state_nxt == FETCH && w_count_nxt < FULL) begin
        w_mem_read_nxt = 1'b1;
        w_mem_addr_nxt = w_fetch_pc_nxt;
      end else begin
        w_mem_read_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_fetch_pc <= RESET_PC;
      r_mem_read <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_mem_read <= w_mem_read_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_count    <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else if (bus.redirect) begin
      r_head <= r_tail;
    end else begin
      if (w_push) begin
        r_q_instr[r_tail] <= bus.mem_rdata;
        r_q_pc[r_tail]    <= r_fetch_pc;
        r_tail            <= r_tail + PW'(1);
      end
      if (w_pop) r_head <= r_head + PW'(1);
    end
  end

  assign bus.mem_read    = r_mem_read;
  assign bus.mem_address = r_mem_addr;
  assign bus.instr_valid = (r_count != '0);
  assign bus.instr       = r_q_instr[r_head];
  assign bus.instr_pc    = r_q_pc[r_head];

endmodule

// File: tb/tb_lc3b_fetch_unit.sv
module tb_lc3b_fetch_unit;

  logic clk;
  logic rst_n;
  lc3b_fetch_unit_if bus ();

  lc3b_fetch_unit #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] req_log[$];
  int unsigned lat;
  int unsigned proto_bad;
  int unsigned errors;
  int unsigned checks;

  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0002) return 16'h5678;
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Memory model: answers each request lat cycles after first seeing it,
  // logs request addresses and counts address-stability violations.
  initial begin : responder
    logic        active;
    logic [15:0] act_addr;
    int unsigned cnt;
    active = 1'b0; act_addr = '0; cnt = 0; proto_bad = 0;
    bus.mem_resp = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.mem_resp = 1'b0; active = 1'b0; cnt = 0;
      end else if (bus.mem_resp) begin
        bus.mem_resp = 1'b0;
      end else if (bus.mem_read) begin
        if (!active) begin
          active = 1'b1; act_addr = bus.mem_address; cnt = 0;
          req_log.push_back(act_addr);
        end else if (bus.mem_address !== act_addr) begin
          proto_bad++;
        end
        if (cnt >= lat) begin
          bus.mem_resp = 1'b1; bus.mem_rdata = memf(act_addr);
          active = 1'b0; cnt = 0;
        end else begin
          cnt++;
        end
      end else if (active) begin
        proto_bad++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fill(input int unsigned need, output bit ok);
    int unsigned k;
    k = 0;
    while (!(req_log.size() >= need && !bus.mem_read && bus.instr_valid) && k < 80) begin
      tick();
      k++;
    end
    ok = (req_log.size() >= need && !bus.mem_read && bus.instr_valid);
  endtask

  // Scoreboard pop: compare the head against the oldest expectation, then accept it.
  task automatic sb_pop(input string nm);
    exp_t e;
    int unsigned k;
    k = 0;
    while (!bus.instr_valid && k < 80) begin
      tick();
      k++;
    end
    checks++;
    if (!bus.instr_valid) begin
      errors++;
      $display("FAIL %s: instr_valid got 0 required 1 (timeout)", nm);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected output instr=%h pc=%h required none", nm, bus.instr, bus.instr_pc);
    end else begin
      e = exp_q.pop_front();
      if (bus.instr !== e.instr || bus.instr_pc !== e.pc) begin
        errors++;
        $display("FAIL %s: got instr=%h pc=%h required instr=%h pc=%h",
                 nm, bus.instr, bus.instr_pc, e.instr, e.pc);
      end
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
    lat = 1; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b required 0", bus.mem_read); end
    checks++; if (bus.mem_address !== 16'h0000) begin errors++; $display("FAIL reset_mem_address: got %h required 0000", bus.mem_address); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b required 0", bus.instr_valid); end
    checks++; if (bus.instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h required 0000", bus.instr); end
    checks++; if (bus.instr_pc !== 16'h0000) begin errors++; $display("FAIL reset_instr_pc: got %h required 0000", bus.instr_pc); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 16'h0000) begin
      errors++; $display("FAIL first_request: got rd=%b addr=%h required rd=1 addr=0000", bus.mem_read, bus.mem_address); end
  endtask

  task automatic test_fill_backpressure();
    bit ok;
    bit held;
    wait_fill(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fill_timeout: queue did not fill, reqs=%0d required 2", req_log.size()); end
    checks++; if (req_log.size() !== 2 || req_log[0] !== 16'h0000 || req_log[1] !== 16'h0002) begin
      errors++; $display("FAIL fill_addresses: got %0d reqs required 0000,0002", req_log.size()); end
    checks++; if (bus.instr !== 16'h1234 || bus.instr_pc !== 16'h0000) begin
      errors++; $display("FAIL fill_head: got %h@%h required 1234@0000", bus.instr, bus.instr_pc); end
    held = 1'b1;
    repeat (4) begin
      tick();
      if (bus.mem_read !== 1'b0 || bus.instr_valid !== 1'b1 || bus.instr !== 16'h1234) held = 1'b0;
    end
    checks++; if (!held) begin errors++; $display("FAIL full_hold: got rd=%b valid=%b required rd=0 valid=1 stable head", bus.mem_read, bus.instr_valid); end
    exp_q.push_back('{16'h1234, 16'h0000});
    exp_q.push_back('{16'h5678, 16'h0002});
    lat = 3;
    sb_pop("fill_pop0");
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 16'h0004) begin
      errors++; $display("FAIL refill_request: got rd=%b addr=%h required rd=1 addr=0004", bus.mem_read, bus.mem_address); end
  endtask

  task automatic test_redirect_discard();
    bit ok;
    int unsigned k;
    int unsigned need;
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 16'h3001;
    exp_q.delete();
    tick();
    bus.redirect = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: instr_valid got %b required 0", bus.instr_valid); end
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 16'h0004) begin
      errors++; $display("FAIL redir_hold: got rd=%b addr=%h required rd=1 addr=0004", bus.mem_read, bus.mem_address); end
    k = 0;
    while (bus.mem_address === 16'h0004 && k < 20) begin
      tick();
      k++;
    end
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 16'h3000 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL redir_restart: got rd=%b addr=%h valid=%b required rd=1 addr=3000 valid=0",
                         bus.mem_read, bus.mem_address, bus.instr_valid); end
    lat = 1;
    exp_q.push_back('{memf(16'h3000), 16'h3000});
    exp_q.push_back('{memf(16'h3002), 16'h3002});
    need = req_log.size() + 2;
    wait_fill(need, ok);
    checks++; if (!ok || req_log[need-3] !== 16'h0004 || req_log[need-2] !== 16'h3000 || req_log[need-1] !== 16'h3002) begin
      errors++; $display("FAIL redir_sequence: got ok=%b reqs=%0d required 0004,3000,3002", ok, req_log.size()); end
    lat = 2;
    sb_pop("redir_first");
  endtask

  task automatic test_redirect_same_cycle();
    bit ok;
    int unsigned need;
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 16'h3004) begin
      errors++; $display("FAIL same_pre: got rd=%b addr=%h required rd=1 addr=3004", bus.mem_read, bus.mem_address); end
    tick();
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0ABC; bus.instr_ready = 1'b1;
    exp_q.delete();
    tick();
    bus.redirect = 1'b0; bus.instr_ready = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL same_flush: instr_valid got %b required 0", bus.instr_valid); end
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 16'h0ABC) begin
      errors++; $display("FAIL same_no_discard: got rd=%b addr=%h required rd=1 addr=0abc", bus.mem_read, bus.mem_address); end
    need = req_log.size() + 2;
    wait_fill(need, ok);
    checks++; if (!ok || bus.instr !== memf(16'h0ABC) || bus.instr_pc !== 16'h0ABC) begin
      errors++; $display("FAIL same_head: got ok=%b %h@%h required %h@0abc", ok, bus.instr, bus.instr_pc, memf(16'h0ABC)); end
  endtask

  task automatic test_wrap();
    bit ok;
    int unsigned need;
    bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFF;
    exp_q.delete();
    tick();
    bus.redirect = 1'b0;
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 16'hFFFE || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_start: got rd=%b addr=%h valid=%b required rd=1 addr=fffe valid=0",
                         bus.mem_read, bus.mem_address, bus.instr_valid); end
    exp_q.push_back('{memf(16'hFFFE), 16'hFFFE});
    exp_q.push_back('{memf(16'h0000), 16'h0000});
    need = req_log.size() + 2;
    wait_fill(need, ok);
    checks++; if (!ok || req_log[need-2] !== 16'hFFFE || req_log[need-1] !== 16'h0000) begin
      errors++; $display("FAIL wrap_addresses: got ok=%b reqs=%0d required fffe,0000", ok, req_log.size()); end
    sb_pop("wrap_fffe");
    sb_pop("wrap_0000");
  endtask

  task automatic test_async_reset();
    bit ok;
    int unsigned need;
    checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL areset_pre: mem_read got %b required 1", bus.mem_read); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_read !== 1'b0 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL areset_immediate: got rd=%b valid=%b required rd=0 valid=0", bus.mem_read, bus.instr_valid); end
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 16'h0000) begin
      errors++; $display("FAIL areset_restart: got rd=%b addr=%h required rd=1 addr=0000", bus.mem_read, bus.mem_address); end
    exp_q.push_back('{16'h1234, 16'h0000});
    exp_q.push_back('{16'h5678, 16'h0002});
    need = req_log.size() + 2;
    wait_fill(need, ok);
    checks++; if (!ok) begin errors++; $display("FAIL areset_fill: queue did not fill, reqs=%0d required %0d", req_log.size(), need); end
    sb_pop("areset_pop0");
    sb_pop("areset_pop1");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fill_backpressure();
    test_redirect_discard();
    test_redirect_same_cycle();
    test_wrap();
    test_async_reset();
    checks++; if (proto_bad !== 0) begin errors++; $display("FAIL mem_protocol: violations got %0d required 0", proto_bad); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3b_fetch_unit.md
Name: lc3b_fetch_unit

Overview:
Instruction fetch stage of the LC-3b datapath, directly upstream of the instruction register. It owns the fetch PC and issues word reads to the instruction memory port. Returned words are buffered, each tagged with its PC, in a small in-order queue. The head of the queue is presented to the IR/decode stage with a valid/ready handshake. A redirect input (branch, JSR, TRAP, JMP) flushes the queue and restarts fetch at a new PC, discarding any read already in flight.

Parameters:
DEPTH, 2, instruction queue entries (power of two, >= 2)
RESET_PC, 16'h0000, fetch PC after reset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
redirect  in  1  flush queue and restart fetch at redirect_pc
redirect_pc  in  16  new fetch PC (lc3b_word); bit 0 ignored, forced 0
mem_read  out  1  instruction memory read request
mem_address  out  16  read address (lc3b_word)
mem_resp  in  1  memory response strobe, one cycle, only while mem_read=1
mem_rdata  in  16  read data, valid when mem_resp=1
instr_valid  out  1  queue head valid
instr  out  16  queue head instruction word; feeds IR "in"
instr_pc  out  16  PC of the queue head instruction (address of instr)
instr_ready  in  1  downstream accepts head this cycle (drives IR load)

Behaviour:
- Reset (async assert, sync release):
  - state=FETCH, fetch_pc=RESET_PC, queue empty (count=0).
  - mem_read=0, mem_address=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- Memory protocol:
  - Once raised, mem_read stays high with mem_address stable until the cycle mem_resp=1.
  - At most one read is outstanding.
  - mem_read may drop or re-raise the cycle after mem_resp.
- States:
  - FETCH:
    - Raise mem_read with mem_address=fetch_pc whenever count < DEPTH and no read is outstanding.
    - On mem_resp with no redirect: push {mem_rdata, fetch_pc} and set fetch_pc = fetch_pc + 2 (16-bit wrap, 16'hFFFE -> 16'h0000).
  - DISCARD:
    - Entered when redirect=1 while a read is outstanding and mem_resp=0 that cycle.
    - Hold mem_read high with the old address; drop the data on mem_resp; return to FETCH next cycle.
    - A new request at the redirected PC starts no earlier than the cycle after the discarded mem_resp.
- Redirect (any state), next edge:
  - count=0 and fetch_pc = {redirect_pc[15:1],1'b0}.
  - Takes priority over a same-cycle push and pop: mem_resp data is dropped and the head is not considered consumed.
  - Redirect with mem_resp=1 in the same cycle goes straight to FETCH, not DISCARD.
  - Redirect while in DISCARD updates fetch_pc and stays in DISCARD.
- Queue:
  - Circular buffer with head/tail pointers mod DEPTH and count 0..DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Push when full cannot occur, because no request is issued at count=DEPTH.
- Output handshake:
  - instr_valid = (count != 0). instr/instr_pc are the head entry.
  - Pop when instr_valid and instr_ready.
  - instr_ready while empty is ignored.
  - Head outputs are stable while valid and not accepted.
- Latency:
  - mem_read rises in the first cycle after reset release.
  - Data returned on mem_resp at edge N becomes visible as instr_valid after edge N (registered push).
  - Sustained throughput is one instruction per memory round trip.

Test Plan:
- Reset release, memory responds 1 cycle after each request with data 16'h1234 then 16'h5678 -> mem_address 0x0000 then 0x0002; instr_valid with instr=16'h1234, instr_pc=0x0000, then 16'h5678/0x0002.
- instr_ready held 0 with DEPTH=2 -> exactly two reads complete, then mem_read stays 0; asserting instr_ready for one cycle triggers a read at 0x0004.
- Redirect to 16'h3001 while a read to 0x0004 is outstanding (mem_resp 3 cycles later) -> instr_valid drops next cycle; mem_read stays high at 0x0004 until resp; data discarded; next request at 0x3000; first valid instr_pc=0x3000.
- Redirect in the same cycle as mem_resp and instr_ready -> response dropped, queue empty, next mem_address = redirect target, no DISCARD state.
- fetch_pc=16'hFFFE, response returned -> instr_pc=16'hFFFE, next mem_address=16'h0000.
- rst_n asserted mid-request -> mem_read=0 and instr_valid=0 immediately (asynchronous); after release fetch restarts at RESET_PC.
